// File: rtl/chu_vga_sprite_pkg.sv
// chu_vga_sprite_pkg
// Shared definitions for the multi-sprite video core: register offsets
// within the slot address space, the packed sprite control word, and
// helpers that size the address fields from the sprite geometry.
package chu_vga_sprite_pkg;

  // Register offsets, decoded from addr[2:0]
  localparam logic [2:0] REG_X0     = 3'd0;
  localparam logic [2:0] REG_Y0     = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_PERIOD = 3'd3;
  localparam logic [2:0] REG_BYPASS = 3'd0;

  // Member order makes the struct line up bit-for-bit with wr_data[4:0]
  // (en is bit 0, anim_en bit 1, frame bits 4:2).
  typedef struct packed {
    logic [2:0] frame;
    logic       anim_en;
    logic       en;
  } sprite_ctrl_t;

  // Width of an index that must hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address width of one sprite's pixel RAM (all frames of that sprite).
  function automatic int ram_addr_width(input int nf, input int sw, input int sh);
    return (nf * sw * sh > 1) ? $clog2(nf * sw * sh) : 1;
  endfunction

endpackage

// File: rtl/sprite_ram.sv
// sprite_ram
// Simple dual-port synchronous RAM holding every animation frame of one
// sprite. One write port, one registered read port; a read of the address
// being written in the same cycle returns the previous contents.
// Ports:
//   clk      system clock
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  registered read data (one cycle after rd_addr)
module sprite_ram #(
  parameter int DW = 12,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/chu_vga_multi_sprite_core.sv
// chu_vga_multi_sprite_core
// Overlays up to NS sprites, each with NF animation frames, on the incoming
// pixel stream. Lowest sprite index wins; pixels equal to KEY_COLOR are
// transparent. Position/control writes go to shadow registers that are
// committed once per video frame when y first reaches V_ACTIVE.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   x, y              pixel coordinates aligned with si_rgb
//   cs, write         slot select and write strobe
//   addr, wr_data     slot word address and write data
//   si_rgb            upstream pixel
//   so_rgb            blended pixel, two cycles after x/y/si_rgb
module chu_vga_multi_sprite_core
  import chu_vga_sprite_pkg::*;
#(
  parameter int            CD        = 12,
  parameter int            NS        = 4,
  parameter int            NF        = 2,
  parameter int            SW        = 32,
  parameter int            SH        = 32,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  parameter int            V_ACTIVE  = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int          LA     = ram_addr_width(NF, SW, SH);
  localparam int          FW     = idx_width(NF);
  localparam logic [10:0] V_LINE = 11'(V_ACTIVE);

  generate
    if (NS < 1 || NS > 8 || NS * NF * SW * SH > 8192) begin : g_param_check
      $error("chu_vga_multi_sprite_core: sprite geometry does not fit the 13-bit pixel address space");
    end
  endgenerate

  // Bus decode
  logic          wr_en;
  logic          pix_we;
  logic          spr_reg_we;
  logic          glb_reg_we;
  logic [12:0]   ram_sprite;
  logic [LA-1:0] ram_wr_addr;
  logic          unused_wr_data;

  assign wr_en          = cs & write;
  assign pix_we         = wr_en & ~addr[13];
  assign spr_reg_we     = wr_en & addr[13] & ~addr[12];
  assign glb_reg_we     = wr_en & addr[13] & addr[12];
  assign ram_sprite     = addr[12:0] >> LA;
  assign ram_wr_addr    = addr[LA-1:0];
  assign unused_wr_data = ^wr_data;

  // Register state. Only the enable bit of the active control word is
  // needed after commit; the animation fields are consumed at the event.
  logic [10:0]  x0_sh     [NS];
  logic [10:0]  y0_sh     [NS];
  sprite_ctrl_t ctrl_sh   [NS];
  logic [10:0]  x0_q      [NS];
  logic [10:0]  y0_q      [NS];
  logic [NS-1:0] en_q;
  logic [7:0]   period    [NS];
  logic [7:0]   tick      [NS];
  logic [FW-1:0] frame_idx [NS];
  logic         bypass;
  logic [10:0]  y_prev;
  logic         frame_ev;

  assign frame_ev = (y == V_LINE) && (y_prev != V_LINE);

  // Register writes, frame-boundary commit and per-sprite animation.
  // Non-blocking commit means a shadow written in the event cycle is only
  // picked up at the following event. Animation uses the control word
  // being committed so a new anim setting acts on this same event.
  always_ff @(posedge clk) begin
    if (reset) begin
      bypass <= 1'b0;
      y_prev <= '0;
      en_q   <= '0;
      for (int i = 0; i < NS; i++) begin
        x0_sh[i]     <= '0;
        y0_sh[i]     <= '0;
        ctrl_sh[i]   <= '0;
        x0_q[i]      <= '0;
        y0_q[i]      <= '0;
        period[i]    <= '0;
        tick[i]      <= '0;
        frame_idx[i] <= '0;
      end
    end else begin
      y_prev <= y;
      if (glb_reg_we && addr[2:0] == REG_BYPASS) bypass <= wr_data[0];
      for (int i = 0; i < NS; i++) begin
        if (spr_reg_we && addr[5:3] == 3'(i)) begin
          case (addr[2:0])
            REG_X0:     x0_sh[i]   <= wr_data[10:0];
            REG_Y0:     y0_sh[i]   <= wr_data[10:0];
            REG_CTRL:   ctrl_sh[i] <= sprite_ctrl_t'(wr_data[4:0]);
            REG_PERIOD: period[i]  <= wr_data[7:0];
            default: ;
          endcase
        end
        if (frame_ev) begin
          x0_q[i] <= x0_sh[i];
          y0_q[i] <= y0_sh[i];
          en_q[i] <= ctrl_sh[i].en;
          if (ctrl_sh[i].anim_en) begin
            if (tick[i] == period[i]) begin
              tick[i]      <= '0;
              frame_idx[i] <= (32'(frame_idx[i]) == NF - 1) ? '0 : frame_idx[i] + FW'(1);
            end else begin
              tick[i] <= tick[i] + 8'd1;
            end
          end else begin
            tick[i]      <= '0;
            frame_idx[i] <= FW'(ctrl_sh[i].frame & 3'(NF - 1));
          end
        end
      end
    end
  end

  // Stage 1 hit test: modular subtraction turns pixels left of / above
  // the sprite origin into large offsets that fail the range check.
  logic [10:0]   dx      [NS];
  logic [10:0]   dy      [NS];
  logic [NS-1:0] hit;
  logic [LA-1:0] rd_addr [NS];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NS; i++) begin
      dx[i]      = x - x0_q[i];
      dy[i]      = y - y0_q[i];
      hit[i]     = en_q[i] && (32'(dx[i]) < SW) && (32'(dy[i]) < SH);
      rd_addr[i] = LA'(32'(frame_idx[i]) * SW * SH
                       + (32'(dy[i]) & (SH - 1)) * SW
                       + (32'(dx[i]) & (SW - 1)));
    end
  end

  logic [CD-1:0] pix [NS];

  generate
    for (genvar g = 0; g < NS; g++) begin : g_ram
      sprite_ram #(
        .DW(CD),
        .AW(LA)
      ) u_ram (
        .clk    (clk),
        .we     (pix_we && ram_sprite == 13'(g)),
        .wr_addr(ram_wr_addr),
        .wr_data(wr_data[CD-1:0]),
        .rd_addr(rd_addr[g]),
        .rd_data(pix[g])
      );
    end
  endgenerate

  // Stage 2 select: scan from the highest index down so the lowest
  // visible sprite is the last assignment and wins.
  logic [NS-1:0] hit_q;
  logic [CD-1:0] si_q;
  logic          byp_q;
  logic [CD-1:0] blend;

  always_comb begin
    blend = si_q;
    if (!byp_q) begin
      for (int i = NS - 1; i >= 0; i--) begin
        if (hit_q[i] && pix[i] != KEY_COLOR) blend = pix[i];
      end
    end
  end

  // Pipeline registers; bypass travels with the pixel so a bypass write
  // only affects pixels entering stage 1 after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      si_q   <= '0;
      byp_q  <= 1'b0;
      so_rgb <= '0;
    end else begin
      hit_q  <= hit;
      si_q   <= si_rgb;
      byp_q  <= bypass;
      so_rgb <= blend;
    end
  end

endmodule
